alu_operand_register_file: RTL and testbench

- Per-thread register file directly upstream of the ALU; drives the ALU `rs`/`rt` operands and captures results.
- Operands are registered in REQUEST; ALU, LSU or immediate results are written back in UPDATE.
- One instance per thread inside each core.
- Exposes read-only special registers %blockIdx, %blockDim and %threadIdx to the program.

---
 rtl/alu_operand_register_file.sv | 83 ++++++++
 tb/tb_alu_operand_register_file.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_register_file.sv
// Per-thread register file feeding the ALU operands: 13 general-purpose registers plus
// the read-only %blockIdx (R13), %blockDim (R14) and %threadIdx (R15) special registers.
module alu_operand_register_file #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [7:0]           block_id,
    input  logic [2:0]           core_state,
    input  logic [3:0]           decoded_rd_address,
    input  logic [3:0]           decoded_rs_address,
    input  logic [3:0]           decoded_rt_address,
    input  logic                 decoded_reg_write_enable,
    input  logic [1:0]           decoded_reg_input_mux,
    input  logic [DATA_BITS-1:0] decoded_immediate,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] lsu_out,
    output logic [DATA_BITS-1:0] rs,
    output logic [DATA_BITS-1:0] rt
);

    localparam logic [2:0] ST_REQUEST = 3'b011;
    localparam logic [2:0] ST_UPDATE  = 3'b110;
    localparam int         NUM_GPR    = 13;

    logic [NUM_GPR-1:0][DATA_BITS-1:0] gpr;
    logic [DATA_BITS-1:0]              block_idx;
    logic [15:0][DATA_BITS-1:0]        rf;
    logic [DATA_BITS-1:0]              wr_data;
    logic                              wr_en;

    // R14/R15 are constants, so they are not storage at all and cannot be written.
    always_comb begin
        rf = '0;
        for (int i = 0; i < NUM_GPR; i++) rf[i] = gpr[i];
        rf[13] = block_idx;
        rf[14] = DATA_BITS'(THREADS_PER_BLOCK);
        rf[15] = DATA_BITS'(THREAD_ID);
    end

    always_comb begin
        wr_data = alu_out;
        case (decoded_reg_input_mux)
            2'b01:   wr_data = lsu_out;
            2'b10:   wr_data = decoded_immediate;
            default: wr_data = alu_out;
        endcase
    end

    assign wr_en = enable && (core_state == ST_UPDATE) && decoded_reg_write_enable &&
                   (decoded_rd_address <= 4'd12) && (decoded_reg_input_mux != 2'b11);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gpr <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_GPR; i++)
                if (decoded_rd_address == 4'(i)) gpr[i] <= wr_data;
        end
    end

    // %blockIdx follows block_id on every enabled edge, whatever the core is doing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            block_idx <= '0;
        else if (enable)
            block_idx <= DATA_BITS'(block_id);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rs <= '0;
            rt <= '0;
        end else if (enable && core_state == ST_REQUEST) begin
            rs <= rf[decoded_rs_address];
            rt <= rf[decoded_rt_address];
        end
    end

endmodule

// File: tb/tb_alu_operand_register_file.sv
// Scoreboarded bench: driver pushes expected operands from a spec-level model, a monitor
// pops them in the WAIT cycle and checks they hold through EXECUTE/UPDATE.
module tb_alu_operand_register_file;

    localparam int TPB = 4;
    localparam int TID = 2;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_REQUEST = 3'd3,
                           S_WAIT = 3'd4, S_EXECUTE = 3'd5, S_UPDATE = 3'd6, S_DONE = 3'd7;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] block_id = '0;
    logic [2:0] core_state = S_IDLE;
    logic [3:0] rd_a = '0, rs_a = '0, rt_a = '0;
    logic       we = 1'b0;
    logic [1:0] mux = '0;
    logic [7:0] imm = '0, alu = '0, lsu = '0;
    logic [7:0] rs, rt;

    alu_operand_register_file #(.THREADS_PER_BLOCK(TPB), .THREAD_ID(TID), .DATA_BITS(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .block_id(block_id),
        .core_state(core_state), .decoded_rd_address(rd_a), .decoded_rs_address(rs_a),
        .decoded_rt_address(rt_a), .decoded_reg_write_enable(we),
        .decoded_reg_input_mux(mux), .decoded_immediate(imm), .alu_out(alu),
        .lsu_out(lsu), .rs(rs), .rt(rt)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got rs=%0d rt=%0d, expected rs=%0d rt=%0d @%0t",
                     name, act[15:8], act[7:0], exp[15:8], exp[7:0], $time);
        end
    endfunction

    // Reference model: the register file as a plain array, updated per the architectural rules.
    logic [7:0]  m_reg [16];
    logic [7:0]  m_rs, m_rt;
    logic [15:0] exp_q [$];

    function automatic void model_reset();
        foreach (m_reg[i]) m_reg[i] = 8'd0;
        m_reg[14] = 8'(TPB);
        m_reg[15] = 8'(TID);
        m_rs = 8'd0;
        m_rt = 8'd0;
    endfunction

    function automatic void model_edge();
        if (!enable) return;
        if (core_state == S_REQUEST) begin
            m_rs = m_reg[rs_a];
            m_rt = m_reg[rt_a];
        end
        if (core_state == S_UPDATE && we && rd_a < 13 && mux != 2'b11)
            m_reg[rd_a] = (mux == 2'b00) ? alu : (mux == 2'b01) ? lsu : imm;
        m_reg[13] = block_id;
    endfunction

    bit rand_bid = 1'b0;

    task automatic step(input logic [2:0] st, input logic en);
        core_state = st;
        enable = en;
        if (rand_bid) block_id = 8'($urandom);
        @(posedge clock);
        model_edge();
        if (st == S_REQUEST) exp_q.push_back({m_rs, m_rt});
        #1;
    endtask

    task automatic instr(input logic [3:0] a_rs, input logic [3:0] a_rt, input logic [3:0] a_rd,
                         input logic w, input logic [1:0] m, input logic [7:0] v_imm,
                         input logic [7:0] v_alu, input logic [7:0] v_lsu,
                         input logic en_req, input logic en_upd, input logic upd_is_exec);
        rs_a = a_rs; rt_a = a_rt; rd_a = a_rd; we = w; mux = m;
        imm = v_imm; alu = v_alu; lsu = v_lsu;
        step(S_FETCH, 1'b1);
        step(S_DECODE, 1'b1);
        step(S_REQUEST, en_req);
        step(S_WAIT, 1'b1);
        step(S_EXECUTE, 1'b1);
        step(upd_is_exec ? S_EXECUTE : S_UPDATE, en_upd);
        step(S_DONE, 1'b1);
    endtask

    task automatic rd2(input logic [3:0] a, input logic [3:0] b);
        instr(a, b, 4'd0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic wr(input logic [3:0] d, input logic [1:0] m, input logic [7:0] v_imm,
                      input logic [7:0] v_alu, input logic [7:0] v_lsu);
        instr(4'd0, 4'd0, d, 1'b1, m, v_imm, v_alu, v_lsu, 1'b1, 1'b1, 1'b0);
    endtask

    // Monitor: operands become valid in WAIT and must hold until the next REQUEST edge.
    logic [15:0] held;
    bit          have_held = 1'b0;
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (core_state == S_WAIT) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", {rs, rt}, 16'hxxxx);
                end else begin
                    held = exp_q.pop_front();
                    have_held = 1'b1;
                    check("operands", {rs, rt}, held);
                end
            end else if ((core_state == S_EXECUTE || core_state == S_UPDATE) && have_held) begin
                check("operand_hold", {rs, rt}, held);
            end
        end
    end

    initial begin
        model_reset();
        #1;
        check("reset_async", {rs, rt}, 16'h0000);
        @(posedge clock); #1;
        check("reset_held", {rs, rt}, 16'h0000);
        reset = 1'b1;

        rd2(4'd14, 4'd15);                                 // expects 4, 2
        wr(4'd3, 2'b00, 8'd0, 8'd44, 8'd0);
        rd2(4'd3, 4'd0);                                   // 44, 0
        wr(4'd5, 2'b10, 8'd200, 8'd1, 8'd2);
        wr(4'd6, 2'b01, 8'd3, 8'd4, 8'd17);
        wr(4'd7, 2'b11, 8'd5, 8'd9, 8'd6);
        rd2(4'd5, 4'd6);                                   // 200, 17
        rd2(4'd7, 4'd7);                                   // 0, 0

        block_id = 8'd3;
        wr(4'd13, 2'b00, 8'd0, 8'd99, 8'd0);
        wr(4'd14, 2'b00, 8'd0, 8'd99, 8'd0);
        wr(4'd15, 2'b00, 8'd0, 8'd99, 8'd0);
        rd2(4'd13, 4'd14);                                 // 3, 4
        rd2(4'd15, 4'd13);                                 // 2, 3

        instr(4'd0, 4'd0, 4'd1, 1'b1, 2'b00, 8'd0, 8'd50, 8'd0, 1'b1, 1'b0, 1'b0);
        rd2(4'd1, 4'd5);                                   // 0, 200
        instr(4'd3, 4'd6, 4'd0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0); // stays 0,200
        instr(4'd0, 4'd0, 4'd8, 1'b1, 2'b00, 8'd0, 8'd66, 8'd0, 1'b1, 1'b1, 1'b1);
        rd2(4'd8, 4'd3);                                   // 0, 44

        wr(4'd2, 2'b00, 8'd0, 8'd77, 8'd0);
        rd2(4'd2, 4'd3);                                   // 77, 44
        // Reset pulled low mid-cycle while an UPDATE to R2 is pending.
        rs_a = 4'd2; rt_a = 4'd3; rd_a = 4'd2; we = 1'b1; mux = 2'b00; alu = 8'd55;
        step(S_FETCH, 1'b1);
        step(S_DECODE, 1'b1);
        step(S_REQUEST, 1'b1);
        step(S_WAIT, 1'b1);
        step(S_EXECUTE, 1'b1);
        core_state = S_UPDATE;
        #2 reset = 1'b0;
        model_reset();
        #1 check("reset_mid_update", {rs, rt}, {m_rs, m_rt});
        #2 core_state = S_IDLE; we = 1'b0;
        reset = 1'b1;
        step(S_IDLE, 1'b1);
        rd2(4'd2, 4'd14);                                  // 0, 4

        // Randomised instruction stream against the model.
        rand_bid = 1'b1;
        for (int k = 0; k < 150; k++) begin
            instr(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 2'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0), 1'b0);
        end

        @(negedge clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
